// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver that deframes scan bytes and folds E0/F0 prefixes into flags.
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       extended,
  output logic       released,
  output logic       err
);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t        state_q, state_d;
  logic [1:0]    clk_s_q, dat_s_q;
  logic          filt_q, filt_d, fall;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [9:0]    sh_q, sh_d;
  logic          ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, ext_q, ext_d, rel_q, rel_d, err_q, err_d;
  logic          good;
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s_q[1];
      else fcnt_d = fcnt_q + 1'b1;
    end
  end
  assign fall = filt_q & ~filt_d;
  // sh_q holds data[7:0], parity[8], stop[9] once all ten post-start bits are in
  assign good = sh_q[9] & (^sh_q[8:0]);
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    tout_d     = '0;
    sh_d       = sh_q;
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    data_d     = data_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (fall && !dat_s_q[1]) begin
        state_d  = SHIFT;
        bitcnt_d = 4'd1;
      end
      SHIFT: if (fall) begin
        sh_d     = {dat_s_q[1], sh_q[9:1]};
        bitcnt_d = bitcnt_q + 4'd1;
        state_d  = bitcnt_q == 4'd10 ? CHECK : SHIFT;
      end else if (tout_q == TW'(TIMEOUT_CYC - 1)) begin
        err_d      = 1'b1;
        state_d    = IDLE;
        bitcnt_d   = 4'd0;
        ext_pend_d = 1'b0;
        rel_pend_d = 1'b0;
      end else tout_d = tout_q + 1'b1;
      CHECK: begin
        state_d  = IDLE;
        bitcnt_d = 4'd0;
        if (!good) begin
          err_d      = 1'b1;
          ext_pend_d = 1'b0;
          rel_pend_d = 1'b0;
        end else if (sh_q[7:0] == 8'hE0) ext_pend_d = 1'b1;
        else if (sh_q[7:0] == 8'hF0) rel_pend_d = 1'b1;
        else begin
          data_d     = sh_q[7:0];
          ext_d      = ext_pend_q;
          rel_d      = rel_pend_q;
          valid_d    = 1'b1;
          ext_pend_d = 1'b0;
          rel_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      bitcnt_q   <= 4'd0;
      tout_q     <= '0;
      sh_q       <= '0;
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s_q    <= {clk_s_q[0], ps2_clk};
      dat_s_q    <= {dat_s_q[0], ps2_data};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      tout_q     <= tout_d;
      sh_q       <= sh_d;
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      err_q      <= err_d;
    end
  assign data     = data_q;
  assign valid    = valid_q;
  assign extended = ext_q;
  assign released = rel_q;
  assign err      = err_q;
endmodule
